// File: rtl/string_fifo_pkg.sv
// string_fifo_pkg
// Shared definitions for the multi-channel string FIFO slave: register
// addresses, STATUS bit positions and CTRL bit positions. Imported by the
// channel sub-module, the top level and the testbench so everyone agrees on
// the register map.
// Ports: none (package).

package string_fifo_pkg;

  // Register indices on the 3-bit Avalon address bus. Addresses 6 and 7 are
  // deliberately absent; they read as zero and ignore writes.
  typedef enum logic [2:0] {
    ADDR_DATA   = 3'd0,
    ADDR_PEEK   = 3'd1,
    ADDR_COUNT  = 3'd2,
    ADDR_STATUS = 3'd3,
    ADDR_CTRL   = 3'd4,
    ADDR_FREE   = 3'd5
  } addr_e;

  // Bit positions inside the STATUS register.
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_UNF   = 3;

  // Bit positions inside the CTRL register. The channel select occupies the
  // low CTRL_SEL_W bits, which is enough for up to 16 channels.
  localparam int CTRL_SEL_W = 4;
  localparam int CTRL_FLUSH = 8;
  localparam int CTRL_CLR   = 9;

endpackage

// File: rtl/string_fifo_ch.sv
// string_fifo_ch
// One FIFO channel: a circular buffer of DEPTH words of DATA_W bits held in
// flops with a combinational head read, plus sticky overflow/underflow flags.
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   push, pop         one-cycle strobes; never asserted together by the top
//   flush             empties the channel, sticky flags untouched
//   clr               clears the sticky flags
//   wdata             word to push
//   head              oldest word, or zero while empty
//   count             occupancy 0..DEPTH
//   empty, full       occupancy flags
//   ovf, unf          sticky overflow / underflow flags

module string_fifo_ch
  import string_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic              clr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  // DEPTH need not be a power of two, so the pointers wrap explicitly
  // rather than relying on natural binary rollover.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full channel or a pop from an empty one is rejected here;
  // the sticky flags below record the attempt instead.
  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign count   = cnt;

  // Pointer and occupancy bookkeeping. Flush only rewinds the pointers; the
  // stored words stay in the array but become unreachable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      cnt <= cnt + CNT_W'(1);
      else if (do_pop && !do_push) cnt <= cnt - CNT_W'(1);
    end
  end

  // Sticky error flags. They survive a flush and are only dropped by an
  // explicit clear or by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (clr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (push && full)  ovf <= 1'b1;
      if (pop && empty)  unf <= 1'b1;
    end
  end

  // Storage array. No reset: contents are only visible through rd_ptr while
  // the channel is non-empty, so stale words never leak out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Zero-latency head so DATA and PEEK reads are valid in the access cycle.
  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/string_fifo_avalon_mc.sv
// string_fifo_avalon_mc
// Multi-channel string FIFO presented as a zero-wait-state Avalon-MM slave.
// Decodes register accesses, holds the channel select (SEL), steers push,
// pop, flush and clear to the selected channel, muxes readdata and ORs all
// channels' sticky flags into the interrupt.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   chipselect     qualifies read/write
//   address        register index (DATA, PEEK, COUNT, STATUS, CTRL, FREE)
//   write          write strobe, one cycle per access
//   writedata      write data
//   read           read strobe; DATA reads pop
//   readdata       combinational read data for the current address
//   irq            high while any channel holds a sticky error

module string_fifo_avalon_mc
  import string_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NUM_CH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CTRL_SEL_W-1:0] sel;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  ctrl_wr;
  logic                  sel_valid;

  logic [DATA_W-1:0] ch_head  [NUM_CH];
  logic [CNT_W-1:0]  ch_count [NUM_CH];
  logic              ch_empty [NUM_CH];
  logic              ch_full  [NUM_CH];
  logic              ch_ovf   [NUM_CH];
  logic              ch_unf   [NUM_CH];

  logic [DATA_W-1:0] sel_head;
  logic [CNT_W-1:0]  sel_count;
  logic              sel_empty;
  logic              sel_full;
  logic              sel_ovf;
  logic              sel_unf;
  logic              irq_any;
  logic              unused_wdata;

  // Access decode. A write wins over a simultaneous read, so such a cycle
  // never pops.
  assign wr_acc    = chipselect & write;
  assign rd_acc    = chipselect & read & ~write;
  assign push_acc  = wr_acc && (address == ADDR_DATA);
  assign pop_acc   = rd_acc && (address == ADDR_DATA);
  assign ctrl_wr   = wr_acc && (address == ADDR_CTRL);
  assign sel_valid = ({28'd0, writedata[CTRL_SEL_W-1:0]} < NUM_CH);

  // Only some writedata bits reach storage or CTRL for narrow DATA_W.
  assign unused_wdata = ^writedata;

  // Channel select register. An out-of-range request leaves SEL alone, and
  // the new value only applies from the next cycle, so a flush or clear in
  // the same CTRL write still hits the old channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel <= '0;
    end else if (ctrl_wr && sel_valid) begin
      sel <= writedata[CTRL_SEL_W-1:0];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    string_fifo_ch #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_acc && (sel == CTRL_SEL_W'(g))),
      .pop     (pop_acc && (sel == CTRL_SEL_W'(g))),
      .flush   (ctrl_wr && writedata[CTRL_FLUSH] && (sel == CTRL_SEL_W'(g))),
      .clr     (ctrl_wr && writedata[CTRL_CLR] && (sel == CTRL_SEL_W'(g))),
      .wdata   (writedata[DATA_W-1:0]),
      .head    (ch_head[g]),
      .count   (ch_count[g]),
      .empty   (ch_empty[g]),
      .full    (ch_full[g]),
      .ovf     (ch_ovf[g]),
      .unf     (ch_unf[g])
    );
  end

  // Pick out the selected channel's view. Written as a compare loop so the
  // 4-bit SEL never indexes past the instantiated channels.
  always_comb begin
    sel_head  = '0;
    sel_count = '0;
    sel_empty = 1'b0;
    sel_full  = 1'b0;
    sel_ovf   = 1'b0;
    sel_unf   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == CTRL_SEL_W'(i)) begin
        sel_head  = ch_head[i];
        sel_count = ch_count[i];
        sel_empty = ch_empty[i];
        sel_full  = ch_full[i];
        sel_ovf   = ch_ovf[i];
        sel_unf   = ch_unf[i];
      end
    end
  end

  // Read data map, purely combinational from address and SEL so the slave
  // runs with zero read latency.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_PEEK: readdata[DATA_W-1:0] = sel_head;
      ADDR_COUNT:           readdata[CNT_W-1:0]  = sel_count;
      ADDR_STATUS: begin
        readdata[STAT_EMPTY] = sel_empty;
        readdata[STAT_FULL]  = sel_full;
        readdata[STAT_OVF]   = sel_ovf;
        readdata[STAT_UNF]   = sel_unf;
      end
      ADDR_CTRL:            readdata[CTRL_SEL_W-1:0] = sel;
      ADDR_FREE:            readdata[CNT_W-1:0]  = CNT_W'(DEPTH) - sel_count;
      default:              readdata = '0;
    endcase
  end

  // Interrupt covers every channel, not just the selected one.
  always_comb begin
    irq_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      irq_any = irq_any | ch_ovf[i] | ch_unf[i];
    end
  end

  assign irq = irq_any;

endmodule

// File: tb/tb_string_fifo_avalon_mc.sv
// tb_string_fifo_avalon_mc
// Self-checking bench for string_fifo_avalon_mc (DATA_W=32, DEPTH=8,
// NUM_CH=4). A table of bus accesses with hand-computed expectations covers
// FIFO ordering and the full/overflow corner; hand-written sequences cover
// wrap-around, channel isolation, underflow, read+write collision and an
// asynchronous reset in the middle of an access.

module tb_string_fifo_avalon_mc;
  import string_fifo_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned NUM_CH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        is_write;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_irq;
    string       name;
  } vec_t;

  vec_t vecs[$];

  string_fifo_avalon_mc #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write      (write),
    .writedata  (writedata),
    .read       (read),
    .readdata   (readdata),
    .irq        (irq)
  );

  // Free-running 10 time-unit clock.
  always #5 clk = ~clk;

  function automatic vec_t wr(input logic [2:0] a, input logic [31:0] d, input string n);
    vec_t v;
    v.is_write = 1'b1;
    v.addr     = a;
    v.wdata    = d;
    v.exp_data = '0;
    v.exp_irq  = 1'b0;
    v.name     = n;
    return v;
  endfunction

  function automatic vec_t rd(input logic [2:0] a, input logic [31:0] e, input logic i, input string n);
    vec_t v;
    v.is_write = 1'b0;
    v.addr     = a;
    v.wdata    = '0;
    v.exp_data = e;
    v.exp_irq  = i;
    v.name     = n;
    return v;
  endfunction

  // One comparison: bumps the counters and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One-cycle write access, driven at the falling edge, committed at the
  // following rising edge.
  task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write      = 1'b1;
    read       = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  // One-cycle read access; readdata and irq are sampled mid-cycle, before
  // any pop commits.
  task automatic busRead(input logic [2:0] a, output logic [31:0] d, output logic i);
    @(negedge clk);
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b0;
    address    = a;
    #1;
    d = readdata;
    i = irq;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  task automatic checkRead(input logic [2:0] a, input logic [31:0] e, input logic ei, input string n);
    logic [31:0] d;
    logic        i;
    busRead(a, d, i);
    checkOutput(n, d, e);
    checkOutput({n, " irq"}, {31'd0, i}, {31'd0, ei});
  endtask

  // Combinational look at readdata with no strobe, so nothing pops.
  task automatic checkIdle(input logic [2:0] a, input logic [31:0] e, input string n);
    @(negedge clk);
    chipselect = 1'b0;
    address    = a;
    #1;
    checkOutput(n, readdata, e);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.is_write) busWrite(v.addr, v.wdata);
    else            checkRead(v.addr, v.exp_data, v.exp_irq, v.name);
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    address    = '0;
    writedata  = '0;

    // Ordered string pushes and pops on ch0.
    vecs.push_back(wr(ADDR_DATA, 32'h61626364, "push abcd"));
    vecs.push_back(wr(ADDR_DATA, 32'h31323334, "push 1234"));
    vecs.push_back(wr(ADDR_DATA, 32'h35363738, "push 5678"));
    vecs.push_back(rd(ADDR_COUNT, 32'd3, 1'b0, "count 3"));
    vecs.push_back(rd(ADDR_DATA, 32'h61626364, 1'b0, "pop abcd"));
    vecs.push_back(rd(ADDR_COUNT, 32'd2, 1'b0, "count 2"));
    vecs.push_back(rd(ADDR_DATA, 32'h31323334, 1'b0, "pop 1234"));
    vecs.push_back(rd(ADDR_COUNT, 32'd1, 1'b0, "count 1"));
    vecs.push_back(rd(ADDR_DATA, 32'h35363738, 1'b0, "pop 5678"));
    vecs.push_back(rd(ADDR_COUNT, 32'd0, 1'b0, "count 0"));
    vecs.push_back(rd(ADDR_STATUS, 32'h1, 1'b0, "status empty"));
    // Fill ch0 to DEPTH and overflow it.
    for (int k = 0; k < 8; k++) vecs.push_back(wr(ADDR_DATA, k, "fill"));
    vecs.push_back(rd(ADDR_STATUS, 32'h2, 1'b0, "status full"));
    vecs.push_back(rd(ADDR_FREE, 32'd0, 1'b0, "free 0"));
    vecs.push_back(rd(ADDR_COUNT, 32'd8, 1'b0, "count 8"));
    vecs.push_back(wr(ADDR_DATA, 32'h99, "ninth push"));
    vecs.push_back(rd(ADDR_COUNT, 32'd8, 1'b1, "count after ovf"));
    vecs.push_back(rd(ADDR_STATUS, 32'h6, 1'b1, "status ovf"));
    vecs.push_back(wr(ADDR_CTRL, 32'h200, "clear flags"));
    vecs.push_back(rd(ADDR_STATUS, 32'h2, 1'b0, "status after clr"));
    vecs.push_back(wr(ADDR_CTRL, 32'h100, "flush"));
    vecs.push_back(rd(ADDR_COUNT, 32'd0, 1'b0, "count after flush"));
    vecs.push_back(rd(ADDR_FREE, 32'd8, 1'b0, "free 8"));
    vecs.push_back(rd(ADDR_STATUS, 32'h1, 1'b0, "status after flush"));

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state.
    checkIdle(ADDR_DATA, 32'h0, "reset data");
    checkRead(ADDR_PEEK, 32'h0, 1'b0, "reset peek");
    checkRead(ADDR_COUNT, 32'h0, 1'b0, "reset count");
    checkRead(ADDR_STATUS, 32'h1, 1'b0, "reset status");
    checkRead(ADDR_CTRL, 32'h0, 1'b0, "reset ctrl");
    checkRead(ADDR_FREE, 32'd8, 1'b0, "reset free");
    checkRead(3'd6, 32'h0, 1'b0, "addr6");
    checkRead(3'd7, 32'h0, 1'b0, "addr7");

    foreach (vecs[k]) applyStimulus(vecs[k]);

    // Wrap-around: after the flush both pointers sit at 0, so six pushes and
    // pops followed by five pushes carry the write pointer past DEPTH-1.
    for (int k = 0; k < 6; k++) busWrite(ADDR_DATA, 32'hA0 + k);
    for (int k = 0; k < 6; k++) checkRead(ADDR_DATA, 32'hA0 + k, 1'b0, "wrap first pass");
    for (int k = 0; k < 5; k++) busWrite(ADDR_DATA, 32'hB0 + k);
    for (int k = 0; k < 5; k++) begin
      checkRead(ADDR_PEEK, 32'hB0 + k, 1'b0, "wrap peek");
      checkRead(ADDR_COUNT, 5 - k, 1'b0, "wrap count after peek");
      checkRead(ADDR_DATA, 32'hB0 + k, 1'b0, "wrap pop");
    end

    // Channel isolation and out-of-range select.
    busWrite(ADDR_DATA, 32'h11);
    busWrite(ADDR_CTRL, 32'h1);
    busWrite(ADDR_DATA, 32'h22);
    busWrite(ADDR_CTRL, 32'h0F);
    checkRead(ADDR_CTRL, 32'h1, 1'b0, "sel kept on bad value");
    checkRead(ADDR_COUNT, 32'd1, 1'b0, "ch1 count");
    checkRead(ADDR_DATA, 32'h22, 1'b0, "ch1 pop");
    busWrite(ADDR_CTRL, 32'h0);
    checkRead(ADDR_COUNT, 32'd1, 1'b0, "ch0 count");
    checkRead(ADDR_DATA, 32'h11, 1'b0, "ch0 pop");

    // Read and write together: the push happens, the pop does not.
    busWrite(ADDR_DATA, 32'h33);
    @(negedge clk);
    chipselect = 1'b1;
    write      = 1'b1;
    read       = 1'b1;
    address    = ADDR_DATA;
    writedata  = 32'h44;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    checkRead(ADDR_COUNT, 32'd2, 1'b0, "rw collision count");
    checkRead(ADDR_DATA, 32'h33, 1'b0, "rw pop first");
    checkRead(ADDR_DATA, 32'h44, 1'b0, "rw pop second");

    // Underflow on empty ch0; flush keeps the sticky flag; irq spans channels.
    checkRead(ADDR_DATA, 32'h0, 1'b0, "underflow pop");
    checkRead(ADDR_COUNT, 32'd0, 1'b1, "count after unf");
    checkRead(ADDR_STATUS, 32'h9, 1'b1, "status unf");
    busWrite(ADDR_CTRL, 32'h100);
    checkRead(ADDR_STATUS, 32'h9, 1'b1, "unf survives flush");
    busWrite(ADDR_CTRL, 32'h1);
    checkRead(ADDR_STATUS, 32'h1, 1'b1, "irq from other channel");
    busWrite(ADDR_CTRL, 32'h0);
    busWrite(ADDR_CTRL, 32'h300);
    checkRead(ADDR_STATUS, 32'h1, 1'b0, "flush+clear");

    // Set up ch2 with three words and a pending error, then reset off-edge
    // in the middle of a push.
    checkRead(ADDR_DATA, 32'h0, 1'b0, "unf before reset");
    busWrite(ADDR_CTRL, 32'h2);
    for (int k = 1; k <= 3; k++) busWrite(ADDR_DATA, k);
    checkRead(ADDR_COUNT, 32'd3, 1'b1, "ch2 count 3");
    checkRead(ADDR_CTRL, 32'h2, 1'b1, "sel 2");
    @(negedge clk);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = ADDR_DATA;
    writedata  = 32'hDEAD;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("irq on async reset", {31'd0, irq}, 32'h0);
    address = ADDR_COUNT;
    #1;
    checkOutput("count on async reset", readdata, 32'h0);
    address = ADDR_CTRL;
    #1;
    checkOutput("sel on async reset", readdata, 32'h0);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      busWrite(ADDR_CTRL, c);
      checkRead(ADDR_COUNT, 32'd0, 1'b0, "count after reset");
      checkRead(ADDR_STATUS, 32'h1, 1'b0, "status after reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/string_fifo_avalon_mc.md
# string_fifo_avalon_mc

Multi-channel, parametrised string FIFO exposed as a zero-wait-state Avalon-MM slave to the NIOS2 processor. It replaces the single fixed-depth string FIFO peripheral and keeps its core map: address 0 push/pop and address 2 occupancy. It adds:
- NUM_CH independent channels, each with configurable depth and word width
- a non-destructive peek
- full/empty and sticky error flags
- per-channel flush
- an error interrupt

## Interface
Parameters:
- DATA_W, 32, FIFO word width in bits (1..32); writedata[DATA_W-1:0] is stored, readdata zero-extended
- DEPTH, 8, words per channel (>= 2, any integer, not restricted to powers of two)
- NUM_CH, 4, number of channels (1..16)

Ports:
- clk  in  1  single system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- chipselect  in  1  slave select; read/write ignored when low
- address  in  3  register index
- write  in  1  write strobe
- writedata  in  32  write data
- read  in  1  read strobe
- readdata  out  32  read data, combinational from address/selected channel (read latency 0)
- irq  out  1  high while any channel has a sticky error flag set

## Operation
Register map (SEL = currently selected channel):
- 0 DATA: write pushes writedata into SEL; read returns SEL head and pops it.
- 1 PEEK: read returns SEL head, no pop; write ignored.
- 2 COUNT: read returns SEL occupancy (0..DEPTH); write ignored.
- 3 STATUS: read returns SEL flags: bit0 empty, bit1 full, bit2 overflow (sticky), bit3 underflow (sticky), other bits 0.
- 4 CTRL:
  - write bits[3:0] sets SEL; a value >= NUM_CH is ignored and SEL is unchanged.
  - write bit8 = 1 flushes SEL.
  - write bit9 = 1 clears SEL's sticky flags.
  - read returns {bits[31:4] = 0, SEL}.
- 5 FREE: read returns DEPTH - COUNT of SEL.
- 6, 7: read 0, write ignored.

Channel behaviour:
- Circular buffer with rd_ptr, wr_ptr and count. Each pointer wraps from DEPTH-1 to 0.
- Push when full: data dropped, pointers and count unchanged, overflow set.
- Pop when empty: readdata = 0, pointers unchanged, underflow set.
- Flush: rd_ptr = wr_ptr = count = 0; sticky flags preserved. Stored data is not cleared; after a flush it is unreachable.
- When CTRL sets both bit8 and bit9 in one write, flush and sticky clear both apply.
- The channel select in a CTRL write (bits[3:0]) takes effect from the next cycle. Flush and clear in the same write target the old SEL.
- irq = OR over all channels of (overflow | underflow), not just SEL.

## Timing
- Reset (reset_n low, asynchronous), for all channels:
  - pointers and count = 0
  - sticky flags = 0
  - SEL = 0
  - irq = 0
  - readdata follows the combinational map, so after reset COUNT reads 0, STATUS reads 0x1, DATA/PEEK read 0.
- Reset asserted mid-access aborts the access. No push or pop commits.
- An access is one cycle, qualified by chipselect & (read | write) at the rising edge.
- readdata is valid in the same cycle the address is presented.
- The pop or push commits at the rising edge ending that cycle; COUNT reflects it on the next cycle.
- The master holds read or write for exactly one cycle per access. Holding for N cycles performs N accesses.
- read and write asserted together: the write takes effect and the read is ignored (no pop).
- Storage is flop/LUT-RAM with combinational read. No block-RAM read latency is allowed.

## Structure
- Package string_fifo_pkg holds:
  - address constants: ADDR_DATA, ADDR_PEEK, ADDR_COUNT, ADDR_STATUS, ADDR_CTRL, ADDR_FREE
  - STATUS bit indices
  - CTRL bit indices: CTRL_FLUSH = 8, CTRL_CLR = 9
- Sub-module string_fifo_ch, instantiated NUM_CH times via generate:
  - inputs: push, pop, flush, clr, wdata
  - outputs: head, count, empty, full, ovf, unf
- The top level does address decode, SEL register, readdata mux and irq OR.

## Test plan
- Push "abcd", "1234", "5678" to ch0. COUNT reads 3, then DATA pops return "abcd", "1234", "5678" in order, with COUNT 2, 1, 0 after each pop.
- DEPTH = 8, push 0..7 to ch0:
  - STATUS = 0x2, FREE = 0.
  - Ninth push: COUNT stays 8, STATUS = 0x6, irq = 1.
  - CTRL write 0x200: irq = 0, STATUS = 0x2.
- Wrap-around: push 6, pop 6, push 5. Pops return the last 5 values in order; PEEK before each pop equals the popped value, and PEEK does not change COUNT.
- Channel isolation:
  - Push 0x11 to ch0.
  - CTRL = 1, push 0x22 to ch1; CTRL = 0x0F (with NUM_CH = 4) leaves SEL = 1.
  - Pop ch1 returns 0x22.
  - CTRL = 0, pop ch0 returns 0x11.
- Pop an empty channel: readdata = 0, COUNT stays 0, underflow set, irq = 1. CTRL 0x100 (flush) leaves the underflow flag set.
- Assert reset_n low mid-sequence with COUNT = 3, off the clock edge: all counts read 0, SEL = 0, irq = 0 immediately, before the next clock edge.
